// File: rtl/output_streamer.sv
// ---------------------------------------------------------------------------
// output_streamer
//   Drains a block of words from the accumulation-buffer writeback port and
//   streams them off-chip over a valid/ready interface, through a 2-entry FIFO.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      one-cycle drain request, sampled only while idle
//   num_words  words to drain, latched on an accepted start (clamped to BANK_DEPTH)
//   ren_wb     read enable to the writeback port
//   radr_wb    read address to the writeback port (equals the read counter)
//   rdata_wb   read data, valid the cycle after ren_wb
//   out_valid  out_data holds a valid word
//   out_ready  downstream accepts the word when out_valid and out_ready are high
//   out_data   head of the internal FIFO
//   busy       drain in progress
//   done       one-cycle pulse when a drain completes
//
// state  | meaning
// IDLE   | waiting for start
// DRAIN  | issuing reads, streaming words out
// FINISH | all reads issued, emptying FIFO and in-flight read
// ---------------------------------------------------------------------------
module output_streamer #(
  parameter int                       DATA_WIDTH      = 64,
  parameter int                       BANK_ADDR_WIDTH = 7,
  parameter logic [BANK_ADDR_WIDTH:0] BANK_DEPTH      = 128
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [BANK_ADDR_WIDTH:0]   num_words,
  output logic                       ren_wb,
  output logic [BANK_ADDR_WIDTH-1:0] radr_wb,
  input  logic [DATA_WIDTH-1:0]      rdata_wb,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       busy,
  output logic                       done
);

  typedef enum logic [1:0] {IDLE, DRAIN, FINISH} state_t;

  state_t                   state;
  logic [BANK_ADDR_WIDTH:0] count;
  logic [BANK_ADDR_WIDTH:0] rd_cnt;
  logic [BANK_ADDR_WIDTH:0] rd_cnt_inc;
  logic                     inflight;
  logic [DATA_WIDTH-1:0]    fifo_mem [2];
  logic                     wr_ptr;
  logic                     rd_ptr;
  logic [1:0]               occ;
  logic [1:0]               occ_next;
  logic [1:0]               level;
  logic                     pop;
  logic                     push;
  logic                     reads_left;
  logic                     complete;

  always_comb begin
    pop        = out_valid & out_ready;
    push       = inflight;
    level      = occ + {1'b0, inflight};
    reads_left = (rd_cnt < count);
    // Only issue a read if the word can be guaranteed a FIFO slot when it lands.
    ren_wb     = (state == DRAIN) && reads_left &&
                 ({1'b0, level} < (3'd2 + {2'b0, pop}));
    rd_cnt_inc = rd_cnt + {{BANK_ADDR_WIDTH{1'b0}}, ren_wb};
    occ_next   = occ + {1'b0, push} - {1'b0, pop};
    // Nothing left to read, nothing in flight, FIFO empties this cycle.
    complete   = (state != IDLE) && !reads_left && !inflight && (occ_next == 2'd0);
  end

  assign radr_wb   = rd_cnt[BANK_ADDR_WIDTH-1:0];
  assign out_valid = (occ != 2'd0);
  assign out_data  = fifo_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      rd_cnt <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            count  <= (num_words > BANK_DEPTH) ? BANK_DEPTH : num_words;
            rd_cnt <= '0;
            busy   <= 1'b1;
            state  <= DRAIN;
          end
        end
        DRAIN: begin
          rd_cnt <= rd_cnt_inc;
          if (complete) begin
            // Only reachable here for an empty drain.
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b1;
            rd_cnt <= '0;
          end else if (rd_cnt_inc == count) begin
            state <= FINISH;
          end
        end
        FINISH: begin
          if (complete) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b1;
            rd_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight    <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      occ         <= 2'd0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      inflight <= ren_wb;
      occ      <= occ_next;
      if (push) begin
        fifo_mem[wr_ptr] <= rdata_wb;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
    end
  end

endmodule

// File: tb/tb_output_streamer.sv
// ---------------------------------------------------------------------------
// tb_output_streamer
//   Self-checking bench for output_streamer. A table of drain cases plus a few
//   random ones; each case is checked against a queue of expected words built
//   from the bank contents, read-address order, FIFO-depth limits, stall
//   stability, done/busy timing and reset behaviour.
// ---------------------------------------------------------------------------
module tb_output_streamer;

  localparam int DW    = 64;
  localparam int AW    = 7;
  localparam int DEPTH = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW:0]   num_words;
  logic          ren_wb;
  logic [AW-1:0] radr_wb;
  logic [DW-1:0] rdata_wb = '0;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [DEPTH];

  int checks = 0;
  int errors = 0;

  output_streamer #(
    .DATA_WIDTH(DW), .BANK_ADDR_WIDTH(AW), .BANK_DEPTH(8'd128)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words),
    .ren_wb(ren_wb), .radr_wb(radr_wb), .rdata_wb(rdata_wb),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Bank model: one-cycle read latency.
  always @(posedge clk) begin
    if (ren_wb) rdata_wb <= mem[radr_wb];
  end

  typedef struct {
    int n;
    int mode;        // 0 ready high, 1 toggle 1/0, 2 low 10 cycles then high, 3 random
    int exp_reads;
    int exp_done;    // cycle of done pulse, -1 when not fixed
    bit fixed_data;  // mem[i] = i+100
    bit restart;     // pulse start again mid-drain
    int reset_after; // assert reset after this many words, -1 none
  } row_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ren"},   {63'd0, ren_wb},    64'd0);
    check({tag, "_radr"},  {57'd0, radr_wb},   64'd0);
    check({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_data"},  out_data,           64'd0);
    check({tag, "_busy"},  {63'd0, busy},      64'd0);
    check({tag, "_done"},  {63'd0, done},      64'd0);
  endtask

  task automatic run_case(input row_t r);
    logic [DW-1:0] q[$];
    int cnt_model, cyc, reads, words, next_addr, done_cnt, done_cyc, last_hs;
    int addr_err, stall_err, busy_err, ovf_err, reads_early, timing_err;
    bit prev_valid, prev_ready, finished, was_reset, done_in_rst;
    logic [DW-1:0] prev_data, exp_word;

    cnt_model = (r.n > DEPTH) ? DEPTH : r.n;
    for (int i = 0; i < DEPTH; i++)
      mem[i] = r.fixed_data ? DW'(i + 100) : {$urandom, $urandom};
    for (int i = 0; i < cnt_model; i++) q.push_back(mem[i]);

    reads = 0; words = 0; next_addr = 0; done_cnt = 0; done_cyc = -1; last_hs = -1;
    addr_err = 0; stall_err = 0; busy_err = 0; ovf_err = 0; reads_early = 0; timing_err = 0;
    prev_valid = 0; prev_ready = 0; prev_data = '0; finished = 0; was_reset = 0;

    @(posedge clk); #1;
    start = 1'b1;
    num_words = r.n[AW:0];
    cyc = 0;
    while (!finished) begin
      @(posedge clk); #1;
      start = r.restart && (cyc == 5);
      if (r.restart && cyc == 5) num_words = 8'd7;
      case (r.mode)
        0: out_ready = 1'b1;
        1: out_ready = (cyc % 2 == 0);
        2: out_ready = (cyc >= 10);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (ren_wb) begin
        if (int'(radr_wb) != next_addr) addr_err++;
        next_addr++;
        reads++;
        if (cyc < 10) reads_early++;
      end
      if (prev_valid && !prev_ready && (!out_valid || out_data !== prev_data)) stall_err++;
      if (out_valid && out_ready) begin
        if (r.mode == 0 && cyc != words + 2) timing_err++;
        exp_word = (q.size() > 0) ? q.pop_front() : 64'hDEAD_0000_0000_BEEF;
        check("word_order", out_data, exp_word);
        words++;
        last_hs = cyc;
      end
      if (reads - words > 2) ovf_err++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (busy) busy_err++;
      end else if (done_cnt == 0 && !busy) begin
        busy_err++;
      end
      prev_valid = out_valid; prev_ready = out_ready; prev_data = out_data;

      if (r.reset_after >= 0 && words == r.reset_after) begin
        #1 rst_n = 1'b0;
        #1 check_all_zero("midrst");
        done_in_rst = 0;
        repeat (3) begin
          @(negedge clk);
          if (done) done_in_rst = 1;
        end
        check("midrst_no_done", {63'd0, done_in_rst}, 64'd0);
        check("midrst_done_cnt", 64'(done_cnt), 64'd0);
        rst_n = 1'b1;
        was_reset = 1;
        finished = 1;
      end else if (done_cnt > 0 && cyc >= done_cyc + 2) begin
        finished = 1;
      end else if (cyc > 3000) begin
        errors++; checks++;
        $display("FAIL timeout n=%0d reads=%0d words=%0d", r.n, reads, words);
        finished = 1;
      end
      cyc++;
    end
    start = 1'b0;

    check("addr_seq", 64'(addr_err), 64'd0);
    check("fifo_bound", 64'(ovf_err), 64'd0);
    check("stall_stable", 64'(stall_err), 64'd0);
    if (!was_reset) begin
      check("read_count", 64'(reads), 64'(r.exp_reads));
      check("word_count", 64'(words), 64'(r.exp_reads));
      check("done_count", 64'(done_cnt), 64'd1);
      check("busy_profile", 64'(busy_err), 64'd0);
      check("queue_empty", 64'(q.size()), 64'd0);
      if (r.exp_reads > 0) check("done_after_last", 64'(done_cyc), 64'(last_hs + 1));
      if (r.exp_done >= 0) check("done_cycle", 64'(done_cyc), 64'(r.exp_done));
      if (r.mode == 0) check("word_timing", 64'(timing_err), 64'd0);
      if (r.mode == 2) check("reads_before_release", 64'(reads_early), 64'd2);
    end
    repeat (2) @(posedge clk);
  endtask

  row_t rows [10];
  row_t rr;

  initial begin
    rows[0] = '{n: 4,   mode: 0, exp_reads: 4,   exp_done: 6,   fixed_data: 1, restart: 0, reset_after: -1};
    rows[1] = '{n: 0,   mode: 0, exp_reads: 0,   exp_done: 1,   fixed_data: 0, restart: 0, reset_after: -1};
    rows[2] = '{n: 200, mode: 0, exp_reads: 128, exp_done: 130, fixed_data: 0, restart: 0, reset_after: -1};
    rows[3] = '{n: 8,   mode: 1, exp_reads: 8,   exp_done: -1,  fixed_data: 0, restart: 0, reset_after: -1};
    rows[4] = '{n: 5,   mode: 2, exp_reads: 5,   exp_done: -1,  fixed_data: 0, restart: 0, reset_after: -1};
    rows[5] = '{n: 16,  mode: 0, exp_reads: 16,  exp_done: 18,  fixed_data: 0, restart: 1, reset_after: -1};
    rows[6] = '{n: 16,  mode: 3, exp_reads: 16,  exp_done: -1,  fixed_data: 0, restart: 0, reset_after: 6};
    rows[7] = '{n: 3,   mode: 0, exp_reads: 3,   exp_done: 5,   fixed_data: 0, restart: 0, reset_after: -1};
    rows[8] = '{n: 1,   mode: 0, exp_reads: 1,   exp_done: 3,   fixed_data: 0, restart: 0, reset_after: -1};
    rows[9] = '{n: 128, mode: 3, exp_reads: 128, exp_done: -1,  fixed_data: 0, restart: 0, reset_after: -1};

    rst_n = 1'b0; start = 1'b0; num_words = '0; out_ready = 1'b0;
    #3 check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_case(rows[i]);

    for (int i = 0; i < 5; i++) begin
      rr.n = $urandom_range(0, 140);
      rr.mode = 3;
      rr.exp_reads = (rr.n > DEPTH) ? DEPTH : rr.n;
      rr.exp_done = -1;
      rr.fixed_data = 0;
      rr.restart = 0;
      rr.reset_after = -1;
      run_case(rr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
